// File: rtl/axi_irq_notify_slave.sv
// rtl/axi_irq_notify_slave.sv - AXI4-Lite slave that counts event edges into a W1C pending flag and drives a level irq
module axi_irq_notify_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              event_in,
  output logic                              irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic          awready_q, awready_d;
  logic          bvalid_q,  bvalid_d;
  logic          arready_q, arready_d;
  logic          rvalid_q,  rvalid_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [DW-1:0] ctrl_q,    ctrl_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] count_q,   count_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic          event_q_q, event_q_d;
  logic          irq_q,     irq_d;

  logic          edge_w;
  logic          wr_en;
  logic          rd_en;
  logic [1:0]    wr_idx;
  logic [1:0]    rd_idx;
  logic [DW-1:0] count_inc;
  logic [DW-1:0] rd_mux;
  logic          unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < DW/8; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  assign wr_idx    = S_AXI_AWADDR[3:2];
  assign rd_idx    = S_AXI_ARADDR[3:2];
  assign edge_w    = event_in & ~event_q_q;
  assign wr_en     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en     = arready_q & S_AXI_ARVALID;
  assign count_inc = count_q + DW'(edge_w);

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      2'd0: rd_mux = ctrl_q;
      2'd1: rd_mux = {{(DW-1){1'b0}}, pending_q};
      2'd2: rd_mux = count_q;
      default: rd_mux = scratch_q;
    endcase
  end

  always_comb begin
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
    bvalid_d  = bvalid_q;
    arready_d = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    count_d   = count_inc;
    scratch_d = scratch_q;
    event_q_d = event_in;
    irq_d     = ctrl_q[0] & pending_q;

    if (wr_en) begin
      bvalid_d = 1'b1;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Read data is the pre-update register value, so it is captured from _q.
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    if (wr_en) begin
      case (wr_idx)
        2'd0: ctrl_d = strb_merge(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
        2'd1: if (S_AXI_WSTRB[0] && S_AXI_WDATA[0]) pending_d = 1'b0;
        2'd2: count_d = strb_merge(count_inc, S_AXI_WDATA, S_AXI_WSTRB);
        default: scratch_d = strb_merge(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
      endcase
    end

    // A new event outranks a same-cycle clear so no edge is ever lost.
    if (edge_w) pending_d = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      count_q   <= '0;
      scratch_q <= '0;
      event_q_q <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      scratch_q <= scratch_d;
      event_q_q <= event_q_d;
      irq_q     <= irq_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;

endmodule

// File: tb/tb_axi_irq_notify_slave.sv
// tb/tb_axi_irq_notify_slave.sv - randomized bench for axi_irq_notify_slave against a transaction-level register model
module tb_axi_irq_notify_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        event_in = 1'b0;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference register file
  logic [31:0] m_ctrl, m_cnt, m_scr;
  logic        m_pend;

  always #5 clk = ~clk;

  axi_irq_notify_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .event_in(event_in), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    m_ctrl = 0; m_cnt = 0; m_scr = 0; m_pend = 0;
  endfunction

  function automatic void model_write(input logic [1:0] idx, input logic [31:0] d,
                                      input logic [3:0] s, input bit ev);
    logic [31:0] base;
    base = m_cnt + (ev ? 32'd1 : 32'd0);
    m_cnt = base;
    case (idx)
      2'd0: m_ctrl = merge(m_ctrl, d, s);
      2'd1: if (s[0] && d[0]) m_pend = 1'b0;
      2'd2: m_cnt = merge(base, d, s);
      default: m_scr = merge(m_scr, d, s);
    endcase
    if (ev) m_pend = 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    case (idx)
      2'd0: return m_ctrl;
      2'd1: return {31'b0, m_pend};
      2'd2: return m_cnt;
      default: return m_scr;
    endcase
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit ev, input int lead, input int stall);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1;
    repeat (lead) begin
      @(negedge clk);
      check("aw_only_no_ready", {awready, wready}, 2'b00);
    end
    wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("wr_ready_pulse", {awready, wready}, 2'b11);
    if (ev) event_in = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; event_in = 1'b0;
    model_write(a[3:2], d, s, ev);
    check("bvalid_okay", {bvalid, bresp, awready, wready}, 5'b10000);
    repeat (stall) begin
      @(negedge clk);
      check("bvalid_hold", {bvalid, awready}, 2'b10);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, input int stall);
    int n;
    logic [31:0] exp;
    exp = model_read(a[3:2]);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check("arready_pulse", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_okay", {rvalid, rresp, arready}, 4'b1000);
    check("rdata", rdata, exp);
    repeat (stall) begin
      @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_drop", rvalid, 0);
  endtask

  task automatic pulse_event();
    logic old_irq;
    old_irq = m_ctrl[0] & m_pend;
    @(negedge clk);
    event_in = 1'b1;
    @(negedge clk);
    event_in = 1'b0;
    m_pend = 1'b1;
    m_cnt  = m_cnt + 1;
    check("irq_lag", irq, old_irq);
    @(negedge clk);
    check("irq_event", irq, m_ctrl[0]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outs", {awready, wready, bvalid, arready, rvalid, irq, bresp, rresp}, 0);
    check("reset_rdata", rdata, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // Write / read back
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'h4, 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // Interrupt flow
    axi_write(4'h8, 32'h0, 4'hF, 0, 0, 0);
    pulse_event();
    axi_read(4'h4, 0);
    axi_read(4'h8, 0);
    axi_write(4'h4, 32'h1, 4'h1, 0, 0, 0);
    check("irq_cleared", irq, 0);
    axi_read(4'h4, 0);

    // Strobes and counter boundaries
    axi_write(4'hC, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    axi_read(4'hC, 0);
    axi_write(4'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    pulse_event();
    axi_read(4'h8, 0);
    axi_write(4'h4, 32'h1, 4'h1, 1, 0, 0);
    axi_read(4'h4, 0);
    axi_write(4'h8, 32'h12345678, 4'b0011, 1, 0, 0);
    axi_read(4'h8, 0);

    // Handshake stalls
    axi_write(4'hC, 32'hCAFE0001, 4'hF, 0, 3, 4);
    axi_read(4'hC, 4);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom_range(0, 3));
      end else if (op == 1) begin
        axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end else begin
        pulse_event();
      end
      check("irq_rand", irq, m_ctrl[0] & m_pend);
    end

    // Asynchronous reset during a pending write response with event_in high
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    pulse_event();
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_reset_bvalid", bvalid, 1);
    event_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", {awready, wready, bvalid, arready, rvalid, irq, bresp, rresp}, 0);
    check("async_reset_rdata", rdata, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_irq", irq, 0);
    axi_read(4'h8, 0);
    axi_read(4'h4, 0);
    event_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_irq_notify_slave.md
# axi_irq_notify_slave

AXI4-Lite slave that latches event pulses from the EMG capture path into a write-1-to-clear status flag and a 32-bit event counter, and raises a level interrupt to the processing system. It is the responder end of the AXI4-Lite register interface that the block-design master VIP and the PS GP port drive. The register map is four 32-bit words: CTRL, STATUS, COUNT and SCRATCH.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: AXI address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- event_in  in  1  event level, synchronous to S_AXI_ACLK.
- irq  out  1  level interrupt, active high.

## Operation
- **Register map.**
  - 0x0 CTRL: R/W, byte-strobed. Bit 0 = IRQ_EN. Bits 31:1 are plain storage.
  - 0x4 STATUS: bit 0 PENDING. A write with WSTRB[0]=1 and WDATA[0]=1 clears it. Bits 31:1 read as 0.
  - 0x8 COUNT: R/W, byte-strobed. Increments by 1 on every event edge and wraps from 0xFFFFFFFF to 0.
  - 0xC SCRATCH: R/W, byte-strobed, no side effects.
- **Event detection.** event_q is a one-cycle delayed copy of event_in. edge = event_in & ~event_q. event_q resets to 1, so a line that is already high at reset release produces no edge.
- **On each edge:** PENDING is set to 1 and COUNT increments.
- **Simultaneous events:**
  - Edge and W1C in the same cycle: the set wins, and PENDING stays 1.
  - Edge and a COUNT write in the same cycle: the written bytes take the write value. Unwritten bytes take the incremented value's bytes.
- **irq** is a flop: irq <= CTRL[0] & STATUS[0].
- **Write channel (one outstanding).**
  - AWREADY and WREADY are asserted together for exactly one cycle. This happens when AWVALID and WVALID are both high, AWREADY is low and BVALID is low.
  - The register update occurs on that same handshake edge.
  - BVALID rises on the following cycle and holds until BREADY is sampled high.
  - AW-only or W-only presentation is not accepted; the slave waits for both.
- **Read channel (one outstanding).**
  - ARREADY is high for one cycle when ARVALID is high, ARREADY is low and RVALID is low.
  - RVALID rises on the next cycle with RDATA captured at the handshake edge. RDATA and RVALID hold until RREADY.
- **Concurrency.** Reads and writes are independent. A read of STATUS or COUNT returns the value before any same-cycle update.
- **Reset.** An asynchronous reset mid-transaction drops all VALID/READY outputs immediately and abandons the transaction with no response.

## Timing
- **Reset values:** AWREADY, WREADY, BVALID, ARREADY, RVALID, irq = 0. RDATA, BRESP, RRESP = 0. All registers = 0; event_q = 1.
- **Write latency:** with both valids high at edge k, the READY pulse is high after edge k and the register is updated at edge k+1. BVALID is high after edge k+1.
- **Read latency:** with ARVALID high at edge k, ARREADY is high after edge k and RVALID is high after edge k+1.
- **Back-to-back throughput:** with BREADY/RREADY held high, one transaction per 3 cycles per channel.
- **Event path:** event_in first sampled high at edge k sets PENDING and updates COUNT after edge k. irq goes high after edge k+1 if IRQ_EN=1.
- **Clear path:** a W1C applied at edge m drops irq after edge m+1.

## Test plan
- **Write/read back:** write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four. Required reads: 0x1, 0x0 (W1C of a clear flag), 0x3, 0x4. All BRESP/RRESP = 0.
- **Interrupt flow:** write CTRL=1, pulse event_in for 1 cycle. Required: STATUS=0x1, COUNT=1, irq high 2 cycles after the pulse. Then write 0x1 to 0x4: irq low, STATUS=0.
- **Strobes:** write 0xAABBCCDD to SCRATCH with WSTRB=4'b0101. Required readback: 0x00BB00DD.
- **Counter boundaries:**
  - Write COUNT=0xFFFFFFFF, then one event: readback 0x0.
  - Event coincident with a W1C: STATUS remains 1.
- **Handshake:** present AWVALID 3 cycles before WVALID, and hold BREADY/RREADY low for 4 cycles. Required: no READY pulse until both valids are high; BVALID/RVALID and RDATA stable until accepted.
- **Reset:** assert ARESETN low during a pending BVALID with event_in high. Required: all outputs 0 asynchronously. After release with event_in still high, COUNT stays 0.
